// File: rtl/fan_pkg.sv
// Shared fan encodings: operating modes, motor speed levels and the
// NATURAL wind pattern, used by the scheduler, off-timer and motor blocks.
package fan_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_MANUAL  = 2'd1,
    MODE_NATURAL = 2'd2,
    MODE_SLEEP   = 2'd3
  } fan_mode_e;

  localparam logic [1:0] LVL_OFF  = 2'd0;
  localparam logic [1:0] LVL_LOW  = 2'd1;
  localparam logic [1:0] LVL_MID  = 2'd2;
  localparam logic [1:0] LVL_HIGH = 2'd3;

  // NATURAL breeze repeats low, mid, high, mid.
  function automatic logic [1:0] nat_level(input logic [1:0] step);
    case (step)
      2'd0:    nat_level = LVL_LOW;
      2'd1:    nat_level = LVL_MID;
      2'd2:    nat_level = LVL_HIGH;
      default: nat_level = LVL_MID;
    endcase
  endfunction

  // Front-panel LEDs are one-hot {SLEEP, NATURAL, MANUAL}, dark in OFF.
  function automatic logic [2:0] mode_led_of(input fan_mode_e m);
    case (m)
      MODE_MANUAL:  mode_led_of = 3'b001;
      MODE_NATURAL: mode_led_of = 3'b010;
      MODE_SLEEP:   mode_led_of = 3'b100;
      default:      mode_led_of = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: pulses tick for one cycle every TICK_CYCLES clocks,
// restarting its count from zero whenever clr is asserted.
module ms_tick_gen #(
  parameter int unsigned TICK_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + ONE;
    if (clr || tick) cnt_d = '0;
  end

  // NOTE: reset is synchronous, so it is sampled inside the clocked block only.
  always_ff @(posedge clk) begin
    if (reset_p) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fan_wind_scheduler.sv
// Fan mode controller: picks the motor speed level each cycle from buttons,
// off-timer expiry, timed wind patterns and ultrasonic proximity pause.
module fan_wind_scheduler
  import fan_pkg::*;
#(
  parameter int unsigned TICK_CYCLES   = 100_000,
  parameter int unsigned NAT_STEP_MS   = 2000,
  parameter int unsigned SLEEP_STEP_MS = 600_000,
  parameter int unsigned DIST_NEAR_CM  = 10,
  parameter int unsigned DIST_HYST_CM  = 5,
  parameter int unsigned DIST_HOLD_MS  = 3000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        mode_btn,
  input  logic        speed_btn,
  input  logic        timer_expired,
  input  logic [11:0] distance,
  input  logic        distance_valid,
  output logic [1:0]  speed_level,
  output logic        motor_en,
  output logic [1:0]  mode,
  output logic [2:0]  mode_led,
  output logic        paused
);

  localparam int unsigned MAX_A  = (NAT_STEP_MS > SLEEP_STEP_MS) ? NAT_STEP_MS : SLEEP_STEP_MS;
  localparam int unsigned MAX_MS = (MAX_A > DIST_HOLD_MS) ? MAX_A : DIST_HOLD_MS;
  localparam int unsigned DW     = $clog2(MAX_MS) + 1;

  localparam logic [DW-1:0] NAT_LAST   = DW'(NAT_STEP_MS - 1);
  localparam logic [DW-1:0] SLEEP_LAST = DW'(SLEEP_STEP_MS - 1);
  localparam logic [DW-1:0] HOLD_LAST  = DW'(DIST_HOLD_MS - 1);
  localparam logic [DW-1:0] ONE        = DW'(1);
  localparam logic [11:0]   NEAR_CM    = 12'(DIST_NEAR_CM);
  localparam logic [11:0]   CLEAR_CM   = 12'(DIST_NEAR_CM + DIST_HYST_CM);

  fan_mode_e     state_q, state_d;
  logic [1:0]    level_q, level_d;
  logic [1:0]    step_q, step_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [DW-1:0] clear_cnt_q, clear_cnt_d;
  logic          paused_q, paused_d;
  logic          last_clear_q, last_clear_d;
  logic [1:0]    speed_level_q;
  logic          motor_en_q;
  logic [2:0]    mode_led_q;

  logic tick, restart, go_off, eff_clear;

  ms_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .clr     (restart),
    .tick    (tick)
  );

  // A sample arriving this cycle is already the most recent one.
  assign eff_clear = distance_valid ? (distance >= CLEAR_CM) : last_clear_q;

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latches are inferred.
    state_d      = state_q;
    level_d      = level_q;
    step_d       = step_q;
    dwell_d      = dwell_q;
    paused_d     = paused_q;
    last_clear_d = last_clear_q;
    clear_cnt_d  = clear_cnt_q;
    restart      = 1'b0;
    go_off       = 1'b0;

    if (tick && !paused_q) begin
      case (state_q)
        MODE_NATURAL: begin
          if (dwell_q == NAT_LAST) begin
            step_d  = step_q + 2'd1;
            level_d = nat_level(step_q + 2'd1);
            restart = 1'b1;
          end else begin
            dwell_d = dwell_q + ONE;
          end
        end
        MODE_SLEEP: begin
          if (dwell_q == SLEEP_LAST) begin
            if (level_q == LVL_MID) begin
              level_d = LVL_LOW;
              restart = 1'b1;
            end else begin
              go_off = 1'b1;
            end
          end else begin
            dwell_d = dwell_q + ONE;
          end
        end
        default: ;
      endcase
    end

    if (paused_q && eff_clear && tick) begin
      if (clear_cnt_q == HOLD_LAST) begin
        paused_d    = 1'b0;
        clear_cnt_d = '0;
      end else begin
        clear_cnt_d = clear_cnt_q + ONE;
      end
    end

    if (distance_valid) begin
      last_clear_d = (distance >= CLEAR_CM);
      if (distance < CLEAR_CM) clear_cnt_d = '0;
      if ((distance < NEAR_CM) && (state_q != MODE_OFF)) paused_d = 1'b1;
    end

    if (timer_expired) begin
      go_off = 1'b1;
    end else if (speed_btn) begin
      case (state_q)
        MODE_OFF: begin
          state_d = MODE_MANUAL;
          level_d = LVL_LOW;
          restart = 1'b1;
        end
        MODE_MANUAL: begin
          if (level_q == LVL_HIGH) begin
            go_off = 1'b1;
          end else begin
            level_d = level_q + 2'd1;
            restart = 1'b1;
          end
        end
        default: go_off = 1'b1;
      endcase
    end else if (mode_btn) begin
      case (state_q)
        MODE_MANUAL: begin
          state_d = MODE_NATURAL;
          step_d  = 2'd0;
          level_d = nat_level(2'd0);
          restart = 1'b1;
        end
        MODE_NATURAL: begin
          state_d = MODE_SLEEP;
          level_d = LVL_MID;
          restart = 1'b1;
        end
        MODE_SLEEP: begin
          state_d = MODE_MANUAL;
          level_d = LVL_LOW;
          restart = 1'b1;
        end
        default: ;
      endcase
    end

    if (go_off) begin
      state_d     = MODE_OFF;
      level_d     = LVL_OFF;
      step_d      = 2'd0;
      paused_d    = 1'b0;
      clear_cnt_d = '0;
      restart     = 1'b1;
    end

    if (restart) dwell_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q       <= MODE_OFF;
      level_q       <= LVL_OFF;
      step_q        <= 2'd0;
      dwell_q       <= '0;
      clear_cnt_q   <= '0;
      paused_q      <= 1'b0;
      last_clear_q  <= 1'b0;
      speed_level_q <= LVL_OFF;
      motor_en_q    <= 1'b0;
      mode_led_q    <= 3'b000;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      step_q        <= step_d;
      dwell_q       <= dwell_d;
      clear_cnt_q   <= clear_cnt_d;
      paused_q      <= paused_d;
      last_clear_q  <= last_clear_d;
      speed_level_q <= paused_d ? LVL_OFF : level_d;
      motor_en_q    <= !paused_d && (level_d != LVL_OFF);
      mode_led_q    <= mode_led_of(state_d);
    end
  end

  assign speed_level = speed_level_q;
  assign motor_en    = motor_en_q;
  assign mode        = state_q;
  assign mode_led    = mode_led_q;
  assign paused      = paused_q;

endmodule

// File: doc/fan_wind_scheduler.md
# fan_wind_scheduler

Mode controller for the multifunctional fan. Decides the DC-motor speed level every cycle from the user buttons, the off-timer's expiry, and the ultrasonic distance. It adds two timed wind patterns on top of plain manual speed: natural breeze and sleep step-down. Its `speed_level`/`motor_en` outputs feed the motor PWM generator and its `mode_led` drives the front-panel LEDs.

## Interface
- `TICK_CYCLES`, 100_000: clk cycles per 1 ms tick (100 MHz clock).
- `NAT_STEP_MS`, 2000: dwell per step of the natural pattern.
- `SLEEP_STEP_MS`, 600_000: dwell per step of the sleep step-down.
- `DIST_NEAR_CM`, 10: distance strictly below this counts as "obstacle near".
- `DIST_HYST_CM`, 5: clear threshold is `DIST_NEAR_CM + DIST_HYST_CM` (at or above counts as clear).
- `DIST_HOLD_MS`, 3000: continuous clear time required before resuming.

Ports:
- `clk` in 1: system clock. One clock domain.
- `reset_p` in 1: reset, synchronous, active-high.
- `mode_btn` in 1: one-cycle pulse, already debounced and edge-detected upstream.
- `speed_btn` in 1: one-cycle pulse, same conditioning.
- `timer_expired` in 1: level from the off-timer; high means the fan must stop.
- `distance` in 12: ultrasonic range in cm.
- `distance_valid` in 1: one-cycle strobe; `distance` is sampled only when this is high.
- `speed_level` out 2: 0 = stopped, 1–3 = low/mid/high.
- `motor_en` out 1: high exactly when `speed_level != 0`.
- `mode` out 2: 0 OFF, 1 MANUAL, 2 NATURAL, 3 SLEEP.
- `mode_led` out 3: one-hot {SLEEP, NATURAL, MANUAL}; 000 in OFF.
- `paused` out 1: proximity pause active.

## Operation
- FSM states: OFF, MANUAL, NATURAL, SLEEP. Reset enters OFF.
- Event priority within one cycle: reset_p > timer_expired > speed_btn > mode_btn.
- timer_expired high: go to OFF and hold OFF while it stays high. All buttons are ignored during that time.
- OFF state:
  - speed_btn → MANUAL at level 1.
  - mode_btn is ignored.
- MANUAL state:
  - speed_btn steps 1→2→3, then the next press goes to OFF.
  - mode_btn → NATURAL.
- NATURAL state:
  - Repeats the level pattern 1,2,3,2, advancing one step every NAT_STEP_MS.
  - Step index is 0 on entry.
  - speed_btn → OFF. mode_btn → SLEEP.
- SLEEP state:
  - Starts at level 2, drops to 1 after SLEEP_STEP_MS, then goes to OFF after another SLEEP_STEP_MS.
  - speed_btn → OFF. mode_btn → MANUAL at level 1.
- Proximity pause:
  - Set when a valid sample has `distance < DIST_NEAR_CM` while not in OFF.
  - While paused:
    - `speed_level` = 0 and `motor_en` = 0.
    - FSM state, step index and dwell counters are frozen.
    - Buttons and timer_expired still act.
  - The clear counter counts ms ticks while the most recent valid sample was clear.
  - Any valid sample below the clear threshold (including the hysteresis band) resets the clear counter to 0.
  - The pause releases when the clear counter reaches DIST_HOLD_MS. Patterns then resume from their frozen position.
  - Entering OFF clears the pause and the clear counter.
- Arithmetic:
  - `distance` is compared unsigned at 12 bits.
  - Dwell counters are sized by `$clog2` of the largest ms parameter + 1.
  - The step index is 2-bit and wraps from 3 to 0.

## Timing
- All outputs are registered. Reset values: speed_level 0, motor_en 0, mode 0, mode_led 000, paused 0.
- Latency is one cycle for every event:
  - button pulse to new speed_level/mode;
  - timer_expired rise to speed_level 0;
  - near sample to paused = 1;
  - final clear tick to paused = 0.
- The ms-tick prescaler and dwell counter restart on every mode entry and every level change. The first NATURAL step therefore occurs exactly `NAT_STEP_MS*TICK_CYCLES` cycles after the entry cycle.
- The prescaler keeps running while paused, but the dwell counter does not count.
- reset_p asserted mid-pattern: OFF on the next edge, with all counters 0.
- mode_btn and speed_btn in the same cycle: only speed_btn is applied.

## Structure
- Shared `fan_pkg` holds:
  - the mode encoding (OFF/MANUAL/NATURAL/SLEEP);
  - the level constants (LVL_OFF..LVL_HIGH);
  - the NATURAL pattern lookup (1,2,3,2).
  The timer and motor blocks use the same encoding.
- Sub-module `ms_tick_gen`: a TICK_CYCLES prescaler with a synchronous `clr` input and a one-cycle `tick` output.
- The FSM, pattern stepping and proximity logic live in the top of this block.

## Test plan
Bench parameters for all scenarios: TICK_CYCLES=10, NAT_STEP_MS=4, SLEEP_STEP_MS=5, DIST_HOLD_MS=3.

1. Reset, then speed_btn ×4 → levels 1,2,3,0. mode is 1,1,1,0 and motor_en tracks the level.
2. From MANUAL, mode_btn → NATURAL. speed_level reads 1, 2, 3, 2, 1 at 0, 40, 80, 120, 160 cycles after entry.
3. mode_btn into SLEEP → level 2, then 1 at +50 cycles, then OFF at +100 cycles with mode_led 000.
4. In NATURAL at level 3, valid distance=5 → paused=1 and level 0 next cycle. Then distance=12 (hysteresis band) → stays paused. Then distance=40 held for 30 cycles → resumes at level 3 with the remaining dwell intact.
5. timer_expired rises in the same cycle as speed_btn during SLEEP → OFF next cycle. Buttons stay ignored while timer_expired is high.
6. speed_btn and mode_btn in the same cycle in MANUAL level 2 → level 3, mode remains MANUAL.
